// File: rtl/lfsr_checker.sv
// lfsr_checker
//   Locks onto a Fibonacci LFSR bit stream and counts bit errors once locked.
//   The checker fills its state register from the received stream, confirms
//   VERIFY_LEN consecutive correct predictions, then free-runs as a flywheel.
//   In flywheel mode a single corrupted bit produces a single error. Lock is
//   dropped after LOSS_LIMIT consecutive mispredictions.
//
// Ports
//   clk            sole clock, rising edge
//   reset_i        synchronous active-high reset
//   taps_load_i    load taps_i and restart the search
//   taps_i         new tap mask (BITS wide)
//   bit_valid_i    bit_i carries a stream bit this cycle
//   bit_i          received serial bit
//   locked_o       registered, high while in LOCKED
//   error_o        registered one-cycle pulse per misprediction in LOCKED
//   error_count_o  saturating error count since reset or tap load
module lfsr_checker #(
   parameter int unsigned     BITS         = 5,
   parameter logic [BITS-1:0] DEFAULT_TAPS = BITS'(5'b10100),
   parameter int unsigned     VERIFY_LEN   = 8,
   parameter int unsigned     LOSS_LIMIT   = 4,
   parameter int unsigned     CNT_BITS     = 8
) (
   input  logic                clk,
   input  logic                reset_i,
   input  logic                taps_load_i,
   input  logic [BITS-1:0]     taps_i,
   input  logic                bit_valid_i,
   input  logic                bit_i,
   output logic                locked_o,
   output logic                error_o,
   output logic [CNT_BITS-1:0] error_count_o
);

   localparam int unsigned FILL_W = $clog2(BITS + 1);
   localparam int unsigned RUN_W  = $clog2(VERIFY_LEN + 1);
   localparam int unsigned MISS_W = $clog2(LOSS_LIMIT + 1);

   localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(BITS - 1);
   localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(VERIFY_LEN - 1);
   localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_LIMIT - 1);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [BITS-1:0]     taps, taps_nxt;
   logic [BITS-1:0]     s, s_nxt;
   logic [FILL_W-1:0]   fill, fill_nxt;
   logic [RUN_W-1:0]    run, run_nxt;
   logic [MISS_W-1:0]   miss, miss_nxt;
   logic [CNT_BITS-1:0] cnt, cnt_nxt;
   logic                err_nxt;
   logic                pred;

   // Next-state and datapath logic. Tap load outranks stream bits.
   always_comb begin
      pred      = ^(s & taps);
      state_nxt = state;
      taps_nxt  = taps;
      s_nxt     = s;
      fill_nxt  = fill;
      run_nxt   = run;
      miss_nxt  = miss;
      cnt_nxt   = cnt;
      err_nxt   = 1'b0;

      if (taps_load_i) begin
         taps_nxt  = taps_i;
         s_nxt     = '0;
         fill_nxt  = '0;
         run_nxt   = '0;
         miss_nxt  = '0;
         cnt_nxt   = '0;
         state_nxt = SEARCH;
      end else if (bit_valid_i) begin
         unique case (state)
            SEARCH: begin
               s_nxt = {s[BITS-2:0], bit_i};
               if (fill == FILL_LAST) begin
                  // An all-zero fill is a fixed point of the LFSR; refill instead.
                  fill_nxt = '0;
                  if (s_nxt != '0) begin
                     state_nxt = VERIFY;
                     run_nxt   = '0;
                  end
               end else begin
                  fill_nxt = fill + 1'b1;
               end
            end
            VERIFY: begin
               s_nxt = {s[BITS-2:0], bit_i};
               if (bit_i == pred) begin
                  if (run == RUN_LAST) begin
                     state_nxt = LOCKED;
                     run_nxt   = '0;
                     miss_nxt  = '0;
                  end else begin
                     run_nxt = run + 1'b1;
                  end
               end else begin
                  state_nxt = SEARCH;
                  fill_nxt  = '0;
                  run_nxt   = '0;
               end
            end
            LOCKED: begin
               // Flywheel: the prediction, not the received bit, advances the state.
               s_nxt = {s[BITS-2:0], pred};
               if (bit_i != pred) begin
                  err_nxt = 1'b1;
                  if (cnt != '1) cnt_nxt = cnt + 1'b1;
                  if (miss == MISS_LAST) begin
                     state_nxt = SEARCH;
                     fill_nxt  = '0;
                     miss_nxt  = '0;
                  end else begin
                     miss_nxt = miss + 1'b1;
                  end
               end else begin
                  miss_nxt = '0;
               end
            end
            default: begin
               state_nxt = SEARCH;
               fill_nxt  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset_i) begin
         state    <= SEARCH;
         taps     <= DEFAULT_TAPS;
         s        <= '0;
         fill     <= '0;
         run      <= '0;
         miss     <= '0;
         cnt      <= '0;
         locked_o <= 1'b0;
         error_o  <= 1'b0;
      end else begin
         state    <= state_nxt;
         taps     <= taps_nxt;
         s        <= s_nxt;
         fill     <= fill_nxt;
         run      <= run_nxt;
         miss     <= miss_nxt;
         cnt      <= cnt_nxt;
         locked_o <= (state_nxt == LOCKED);
         error_o  <= err_nxt;
      end
   end

   assign error_count_o = cnt;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker
//   Scoreboard bench for lfsr_checker (BITS=5, taps 10100). The driver applies
//   one input vector per cycle and queues the expected registered outputs;
//   a monitor pops one entry after each rising edge and compares.
module tb_lfsr_checker;

   logic       clk;
   logic       reset_i;
   logic       taps_load_i;
   logic [4:0] taps_i;
   logic       bit_valid_i;
   logic       bit_i;
   logic       locked_o;
   logic       error_o;
   logic [7:0] error_count_o;

   lfsr_checker #(
      .BITS         (5),
      .DEFAULT_TAPS (5'b10100),
      .VERIFY_LEN   (8),
      .LOSS_LIMIT   (4),
      .CNT_BITS     (8)
   ) dut (
      .clk           (clk),
      .reset_i       (reset_i),
      .taps_load_i   (taps_load_i),
      .taps_i        (taps_i),
      .bit_valid_i   (bit_valid_i),
      .bit_i         (bit_i),
      .locked_o      (locked_o),
      .error_o       (error_o),
      .error_count_o (error_count_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       lk;
      logic       er;
      logic [7:0] cnt;
      bit         chk_er;
      string      name;
   } exp_t;

   exp_t q[$];
   int   vectors     = 0;
   int   miscompares = 0;
   logic [4:0] g;

   // Reference PRBS source: x^5 + x^3 + 1 style recurrence b[n] = b[n-5] ^ b[n-3].
   task automatic gen(output logic b);
      b = g[4] ^ g[2];
      g = {g[3:0], b};
   endtask

   task automatic cyc(input logic rst, input logic ld, input logic [4:0] tp,
                      input logic v, input logic b,
                      input logic lk, input logic er, input logic [7:0] cnt,
                      input bit chk_er, input string name);
      exp_t e;
      @(negedge clk);
      reset_i     = rst;
      taps_load_i = ld;
      taps_i      = tp;
      bit_valid_i = v;
      bit_i       = b;
      e.lk = lk; e.er = er; e.cnt = cnt; e.chk_er = chk_er; e.name = name;
      q.push_back(e);
   endtask

   task automatic do_reset();
      cyc(1'b1, 1'b0, 5'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, "reset");
   endtask

   // Clean stream from a fresh search: lock expected on the 13th valid bit.
   task automatic clean_run(input int nbits, input logic [7:0] cnt, input string name);
      logic b;
      for (int i = 1; i <= nbits; i++) begin
         gen(b);
         cyc(1'b0, 1'b0, 5'b0, 1'b1, b, (i >= 13), 1'b0, cnt, 1'b1, name);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         vectors++;
         if (locked_o !== e.lk || (e.chk_er && error_o !== e.er) || error_count_o !== e.cnt) begin
            miscompares++;
            $display("FAIL %s vec %0d: got locked=%b error=%b count=%0d, expected locked=%b error=%b count=%0d",
                     e.name, vectors, locked_o, error_o, error_count_o, e.lk, e.er, e.cnt);
         end
      end
   end

   initial begin
      logic b;
      logic [7:0] k8;
      reset_i = 1'b1; taps_load_i = 1'b0; taps_i = '0; bit_valid_i = 1'b0; bit_i = 1'b0;

      // Reset state, then clean PRBS for 1000 bits.
      do_reset();
      g = 5'b00001;
      clean_run(1000, 8'd0, "prbs");

      // Single flip while locked.
      gen(b);
      cyc(1'b0, 1'b0, 5'b0, 1'b1, ~b, 1'b1, 1'b1, 8'd1, 1'b1, "single_flip");
      for (int i = 0; i < 20; i++) begin
         gen(b);
         cyc(1'b0, 1'b0, 5'b0, 1'b1, b, 1'b1, 1'b0, 8'd1, 1'b1, "post_flip");
      end

      // Burst of four flips drops lock; relock 13 valid bits later.
      do_reset();
      g = 5'b00001;
      clean_run(13, 8'd0, "burst_lock");
      for (int k = 1; k <= 4; k++) begin
         gen(b);
         cyc(1'b0, 1'b0, 5'b0, 1'b1, ~b, (k < 4), 1'b1, 8'(k), 1'b1, "burst");
      end
      clean_run(20, 8'd4, "relock");

      // All-zero stream never locks.
      do_reset();
      for (int i = 0; i < 100; i++)
         cyc(1'b0, 1'b0, 5'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, "zero_stream");

      // Zero taps never lock on a live PRBS.
      cyc(1'b0, 1'b1, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, "load_zero_taps");
      g = 5'b00001;
      for (int i = 0; i < 60; i++) begin
         gen(b);
         cyc(1'b0, 1'b0, 5'b0, 1'b1, b, 1'b0, 1'b0, 8'd0, 1'b1, "zero_taps");
      end

      // Gapped valid: lock point counted in valid bits only.
      do_reset();
      g = 5'b00001;
      for (int n = 1; n <= 40; n++) begin
         gen(b);
         cyc(1'b0, 1'b0, 5'b0, 1'b1, b, (n >= 13), 1'b0, 8'd0, 1'b1, "gapped");
         cyc(1'b0, 1'b0, 5'b0, 1'b0, 1'($urandom_range(0, 1)), (n >= 13), 1'b0, 8'd0, 1'b1, "gap_idle");
      end

      // Tap reload while locked with one error logged; the load-cycle bit is discarded.
      gen(b);
      cyc(1'b0, 1'b0, 5'b0, 1'b1, ~b, 1'b1, 1'b1, 8'd1, 1'b1, "pre_load_flip");
      gen(b);
      cyc(1'b0, 1'b0, 5'b0, 1'b1, b, 1'b1, 1'b0, 8'd1, 1'b1, "pre_load_clean");
      gen(b);
      cyc(1'b0, 1'b1, 5'b10100, 1'b1, b, 1'b0, 1'b0, 8'd0, 1'b1, "load_locked");
      clean_run(20, 8'd0, "after_load");

      // Reset together with a zero-tap load: default taps win.
      gen(b);
      cyc(1'b1, 1'b1, 5'b00000, 1'b1, b, 1'b0, 1'b0, 8'd0, 1'b1, "reset_and_load");
      clean_run(20, 8'd0, "after_reset_load");

      // Error counter saturation with isolated flips (lock is held throughout).
      for (int k = 1; k <= 258; k++) begin
         k8 = (k > 255) ? 8'd255 : 8'(k);
         gen(b);
         cyc(1'b0, 1'b0, 5'b0, 1'b1, ~b, 1'b1, 1'b1, k8, (k <= 255), "sat_flip");
         gen(b);
         cyc(1'b0, 1'b0, 5'b0, 1'b1, b, 1'b1, 1'b0, k8, 1'b1, "sat_clean");
      end

      // Reset mid-stream while locked.
      do_reset();

      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      #2;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected entries left, expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
